// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing with frame-aligned start/stop; VGA_PIPE_ALIGN_EN adds a one-pixel decode delay stage
module vga_timing_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYN   = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYN   = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       busy,
    output logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       vidon,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYN + V_BP;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic [9:0]    hc_nxt;
    logic [9:0]    vc_nxt;
    logic          last_pix;
    logic          vid_q;
    logic          hs_q;
    logic          vs_q;

    function automatic logic vis_of(input logic [9:0] h, input logic [9:0] v);
        return (int'(h) < H_VIS) && (int'(v) < V_VIS);
    endfunction

    function automatic logic hs_of(input logic [9:0] h);
        return !((int'(h) >= H_VIS + H_FP) && (int'(h) < H_VIS + H_FP + H_SYN));
    endfunction

    function automatic logic vs_of(input logic [9:0] v);
        return !((int'(v) >= V_VIS + V_FP) && (int'(v) < V_VIS + V_FP + V_SYN));
    endfunction

    always_comb begin
        div_nxt  = (div == DIV_LAST) ? '0 : div + 1'b1;
        hc_nxt   = (hc == H_LAST) ? 10'd0 : hc + 10'd1;
        vc_nxt   = vc;
        if (hc == H_LAST) begin
            vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end
        last_pix = (hc == H_LAST) && (vc == V_LAST);
    end

    // pix_en is registered: it is loaded with "next divider hits its last count"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            div         <= '0;
            pix_en      <= 1'b0;
            hc          <= 10'd0;
            vc          <= 10'd0;
            vid_q       <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        div         <= '0;
                        pix_en      <= (CLK_DIV == 1);
                        hc          <= 10'd0;
                        vc          <= 10'd0;
                        vid_q       <= vis_of(10'd0, 10'd0);
                        hs_q        <= hs_of(10'd0);
                        vs_q        <= vs_of(10'd0);
                        frame_start <= 1'b1;
                        line_start  <= 1'b1;
                    end
                end
                default: begin
                    div    <= div_nxt;
                    pix_en <= (div_nxt == DIV_LAST);
                    if (state == RUN && !en) begin
                        state <= DRAIN;
                    end else if (state == DRAIN && en) begin
                        state <= RUN;
                    end
                    if (pix_en) begin
                        // Only a drain with en still low may stop, and only after the frame's last pixel
                        if (state == DRAIN && !en && last_pix) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            div    <= '0;
                            pix_en <= 1'b0;
                            hc     <= 10'd0;
                            vc     <= 10'd0;
                            vid_q  <= 1'b0;
                            hs_q   <= 1'b1;
                            vs_q   <= 1'b1;
                        end else begin
                            hc          <= hc_nxt;
                            vc          <= vc_nxt;
                            vid_q       <= vis_of(hc_nxt, vc_nxt);
                            hs_q        <= hs_of(hc_nxt);
                            vs_q        <= vs_of(vc_nxt);
                            line_start  <= (hc_nxt == 10'd0);
                            frame_start <= (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
                        end
                    end
                end
            endcase
        end
    end

`ifdef VGA_PIPE_ALIGN_EN
    logic vid_p;
    logic hs_p;
    logic vs_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_p <= 1'b0;
            hs_p  <= 1'b1;
            vs_p  <= 1'b1;
        end else if (state == IDLE) begin
            vid_p <= 1'b0;
            hs_p  <= 1'b1;
            vs_p  <= 1'b1;
        end else if (pix_en) begin
            vid_p <= vid_q;
            hs_p  <= hs_q;
            vs_p  <= vs_q;
        end
    end

    assign vidon = vid_p;
    assign hs    = hs_p;
    assign vs    = vs_p;
`else
    assign vidon = vid_q;
    assign hs    = hs_q;
    assign vs    = vs_q;
`endif

endmodule
